// File: rtl/cache_mem_responder_if.sv
// rtl/cache_mem_responder_if.sv - cache-to-memory request/response bundle
interface cache_mem_responder_if;
    logic        cache_MemRead;
    logic        cache_MemWrite;
    logic [15:0] cache_mem_addr;
    logic [15:0] cache_mem_write_data;
    logic        MemDataValid;
    logic [15:0] mem_read_data;
    logic        MemWriteDone;
    logic        MemBusy;

    // Cache side: issues requests, consumes responses
    modport master (
        output cache_MemRead,
        output cache_MemWrite,
        output cache_mem_addr,
        output cache_mem_write_data,
        input  MemDataValid,
        input  mem_read_data,
        input  MemWriteDone,
        input  MemBusy
    );

    // Memory side: consumes requests, drives responses
    modport slave (
        input  cache_MemRead,
        input  cache_MemWrite,
        input  cache_mem_addr,
        input  cache_mem_write_data,
        output MemDataValid,
        output mem_read_data,
        output MemWriteDone,
        output MemBusy
    );
endinterface

// File: rtl/cache_mem_responder.sv
// rtl/cache_mem_responder.sv - multi-cycle main memory answering cache block reads and word writes
module cache_mem_responder #(
    parameter int    LATENCY     = 4,
    parameter int    BLOCK_WORDS = 8,
    parameter int    MEM_WORDS   = 1024,
    parameter string INIT_FILE   = ""
) (
    input  logic                        clk,
    input  logic                        rst,
    cache_mem_responder_if.slave        bus
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int BW = $clog2(BLOCK_WORDS);
    localparam int LW = 4;

    // Beat counter runs one past the last beat so the closing edge can be told apart
    localparam logic [BW:0]   BEAT_END = (BW+1)'(BLOCK_WORDS);
    localparam logic [AW-1:0] BLK_MASK = AW'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        RD_BURST = 2'd2,
        WR_WAIT  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   lat_cnt_q, lat_cnt_d;
    logic [BW:0]     beat_cnt_q, beat_cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [15:0]     wdata_q, wdata_d;
    logic            valid_q, valid_d;
    logic [15:0]     rdata_q, rdata_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic            mem_we;

    logic [15:0]     mem_q [MEM_WORDS];

    logic [AW-1:0]   req_idx;
    logic [AW-1:0]   req_base;
    logic            unused_addr;

    assign req_idx     = bus.cache_mem_addr[AW:1];
    assign req_base    = req_idx & ~BLK_MASK;
    assign unused_addr = ^{bus.cache_mem_addr[0], bus.cache_mem_addr[15:AW+1]};

    assign bus.MemDataValid  = valid_q;
    assign bus.mem_read_data = rdata_q;
    assign bus.MemWriteDone  = done_q;
    assign bus.MemBusy       = busy_q;

    // Next-state and registered-output values for the request FSM
    always_comb begin
        state_d    = state_q;
        lat_cnt_d  = lat_cnt_q;
        beat_cnt_d = beat_cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        valid_d    = 1'b0;
        rdata_d    = rdata_q;
        done_d     = 1'b0;
        busy_d     = busy_q;
        mem_we     = 1'b0;

        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.cache_MemWrite) begin
                    state_d   = WR_WAIT;
                    addr_d    = req_idx;
                    wdata_d   = bus.cache_mem_write_data;
                    lat_cnt_d = LW'(LATENCY - 1);
                    busy_d    = 1'b1;
                end else if (bus.cache_MemRead) begin
                    addr_d     = req_base;
                    beat_cnt_d = '0;
                    busy_d     = 1'b1;
                    if (LATENCY == 1) begin
                        state_d   = RD_BURST;
                        lat_cnt_d = '0;
                    end else begin
                        state_d   = RD_WAIT;
                        lat_cnt_d = LW'(LATENCY - 2);
                    end
                end
            end

            RD_WAIT: begin
                if (lat_cnt_q == '0) begin
                    state_d = RD_BURST;
                end else begin
                    lat_cnt_d = lat_cnt_q - LW'(1);
                end
            end

            RD_BURST: begin
                if (beat_cnt_q == BEAT_END) begin
                    // Last beat already shown: close the burst, data stays on the bus
                    state_d    = IDLE;
                    busy_d     = 1'b0;
                    beat_cnt_d = '0;
                end else begin
                    valid_d    = 1'b1;
                    rdata_d    = mem_q[addr_q + AW'(beat_cnt_q)];
                    beat_cnt_d = beat_cnt_q + (BW+1)'(1);
                end
            end

            WR_WAIT: begin
                if (lat_cnt_q == '0) begin
                    mem_we  = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    lat_cnt_d = lat_cnt_q - LW'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters, latched request and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            lat_cnt_q  <= '0;
            beat_cnt_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            valid_q    <= 1'b0;
            rdata_q    <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lat_cnt_q  <= lat_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            valid_q    <= valid_d;
            rdata_q    <= rdata_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    // Word array commit; a reset edge drops a write that is due on that same edge
    always_ff @(posedge clk) begin
        if (rst && mem_we) begin
            mem_q[addr_q] <= wdata_q;
        end
    end
endmodule
